// File: rtl/serv_rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serv_rf_pkg                                                                |
// | Shared constants for the register-file RAM arbiter.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package serv_rf_pkg;

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    localparam int c_csr_regs = 4;

    // 32 GPRs plus the CSRs, each 32 bits, packed into WIDTH-bit words
    function automatic int rf_depth(input int width, input int csr_regs);
        return (32 + csr_regs) * 32 / width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_rf_clr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serv_rf_clr_seq                                                            |
// | Post-reset word counter for RAM clearing; releases the core hold when done.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serv_rf_clr_seq #(
    parameter int DEPTH = 144,
    parameter int L2D   = 8
) (
    input  logic           clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    output logic [L2D-1:0] o_clr_cnt,
    output logic           o_done,
    output logic           o_cpu_hold
);

    localparam logic [L2D-1:0] c_last = L2D'(DEPTH - 1);

    logic [L2D-1:0] r_cnt;
    logic           r_hold;
    logic           w_done;

    assign w_done = (r_cnt == c_last);

    // Counter parks on the last word so it never wraps after the clear ends
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_hold <= 1'b1;
        end else if (i_en) begin
            if (w_done) begin
                r_hold <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clr_cnt  = r_cnt;
    assign o_done     = w_done;
    assign o_cpu_hold = r_hold;

endmodule
`default_nettype wire

// File: rtl/serv_rf_ram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serv_rf_ram_arb                                                            |
// | RF RAM initialiser and core-priority arbiter with a word-wide debug port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serv_rf_ram_arb
    import serv_rf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CSR_REGS = c_csr_regs,
    parameter int DEPTH    = rf_depth(WIDTH, CSR_REGS),
    parameter int L2D      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [L2D-1:0]   i_cpu_waddr,
    input  logic [WIDTH-1:0] i_cpu_wdata,
    input  logic             i_cpu_wen,
    input  logic [L2D-1:0]   i_cpu_raddr,
    input  logic             i_cpu_ren,
    output logic [WIDTH-1:0] o_cpu_rdata,
    output logic             o_cpu_hold,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [L2D-1:0]   i_dbg_addr,
    input  logic [WIDTH-1:0] i_dbg_wdata,
    output logic             o_dbg_gnt,
    output logic [WIDTH-1:0] o_dbg_rdata,
    output logic             o_dbg_rvalid,
    output logic [L2D-1:0]   o_ram_waddr,
    output logic [WIDTH-1:0] o_ram_wdata,
    output logic             o_ram_wen,
    output logic [L2D-1:0]   o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [WIDTH-1:0] i_ram_rdata
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [L2D-1:0]   w_clr_cnt;
    logic             w_clr_done;
    logic             w_dbg_wr_gnt;
    logic             w_dbg_rd_gnt;
    logic             r_dbg_rvalid;
    logic [WIDTH-1:0] r_dbg_rdata;

    serv_rf_clr_seq #(
        .DEPTH (DEPTH),
        .L2D   (L2D)
    ) u_clr_seq (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_en       (r_state == c_st_clear),
        .o_clr_cnt  (w_clr_cnt),
        .o_done     (w_clr_done),
        .o_cpu_hold (o_cpu_hold)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_clear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_clear && w_clr_done) begin
            w_state_nxt = c_st_run;
        end
    end

    // Unowned ports keep the core's address/data so the RAM sees no toggling
    always_comb begin
        w_dbg_wr_gnt = 1'b0;
        w_dbg_rd_gnt = 1'b0;
        o_ram_waddr  = i_cpu_waddr;
        o_ram_wdata  = i_cpu_wdata;
        o_ram_wen    = 1'b0;
        o_ram_raddr  = i_cpu_raddr;
        o_ram_ren    = 1'b0;
        if (r_state == c_st_clear) begin
            o_ram_waddr = w_clr_cnt;
            o_ram_wdata = '0;
            o_ram_wen   = i_rst_n;
        end else begin
            w_dbg_wr_gnt = !i_cpu_wen && i_dbg_req &&  i_dbg_we;
            w_dbg_rd_gnt = !i_cpu_ren && i_dbg_req && !i_dbg_we;
            o_ram_wen    = i_cpu_wen | w_dbg_wr_gnt;
            o_ram_ren    = i_cpu_ren | w_dbg_rd_gnt;
            if (w_dbg_wr_gnt) begin
                o_ram_waddr = i_dbg_addr;
                o_ram_wdata = i_dbg_wdata;
            end
            if (w_dbg_rd_gnt) begin
                o_ram_raddr = i_dbg_addr;
            end
        end
    end

    assign o_dbg_gnt = w_dbg_wr_gnt | w_dbg_rd_gnt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_dbg_rd_gnt;
            if (r_dbg_rvalid) begin
                r_dbg_rdata <= i_ram_rdata;
            end
        end
    end

    // RAM data arrives in the rvalid cycle; bypass it then, hold the copy after
    assign o_dbg_rdata  = r_dbg_rvalid ? i_ram_rdata : r_dbg_rdata;
    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_cpu_rdata  = i_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serv_rf_ram_arb                                                         |
// | Directed self-checking bench for serv_rf_ram_arb with a behavioural RAM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serv_rf_ram_arb;

    localparam int WIDTH = 8;
    localparam int DEPTH = 144;
    localparam int L2D   = 8;

    logic             clk;
    logic             rst_n;
    logic [L2D-1:0]   cpu_waddr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_wen;
    logic [L2D-1:0]   cpu_raddr;
    logic             cpu_ren;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_hold;
    logic             dbg_req;
    logic             dbg_we;
    logic [L2D-1:0]   dbg_addr;
    logic [WIDTH-1:0] dbg_wdata;
    logic             dbg_gnt;
    logic [WIDTH-1:0] dbg_rdata;
    logic             dbg_rvalid;
    logic [L2D-1:0]   ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_wen;
    logic [L2D-1:0]   ram_raddr;
    logic             ram_ren;
    logic [WIDTH-1:0] ram_rdata;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_asserts = 0;
    int n_fail    = 0;

    serv_rf_ram_arb dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_cpu_waddr  (cpu_waddr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_wen    (cpu_wen),
        .i_cpu_raddr  (cpu_raddr),
        .i_cpu_ren    (cpu_ren),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_hold   (cpu_hold),
        .i_dbg_req    (dbg_req),
        .i_dbg_we     (dbg_we),
        .i_dbg_addr   (dbg_addr),
        .i_dbg_wdata  (dbg_wdata),
        .o_dbg_gnt    (dbg_gnt),
        .o_dbg_rdata  (dbg_rdata),
        .o_dbg_rvalid (dbg_rvalid),
        .o_ram_waddr  (ram_waddr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_wen    (ram_wen),
        .o_ram_raddr  (ram_raddr),
        .o_ram_ren    (ram_ren),
        .i_ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write on an address collision
    always @(posedge clk) begin
        if (ram_wen && ram_waddr < L2D'(DEPTH)) mem[ram_waddr] <= ram_wdata;
        if (ram_ren && ram_raddr < L2D'(DEPTH)) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_read(input logic [L2D-1:0] addr, input logic [WIDTH-1:0] exp);
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = addr;
        #1;
        check("rd_gnt",   32'(dbg_gnt),   32'd1);
        check("rd_ren",   32'(ram_ren),   32'd1);
        check("rd_raddr", 32'(ram_raddr), 32'(addr));
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        check("rd_rvalid", 32'(dbg_rvalid), 32'd1);
        check("rd_rdata",  32'(dbg_rdata),  32'(exp));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        ram_rdata = '0;
        rst_n     = 1'b0;
        cpu_waddr = '0;
        cpu_wdata = '0;
        cpu_wen   = 1'b0;
        cpu_raddr = '0;
        cpu_ren   = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'h05;
        dbg_wdata = 8'hA5;

        repeat (2) @(negedge clk);
        #1;
        check("rst_hold",   32'(cpu_hold),   32'd1);
        check("rst_wen",    32'(ram_wen),    32'd0);
        check("rst_ren",    32'(ram_ren),    32'd0);
        check("rst_gnt",    32'(dbg_gnt),    32'd0);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_rdata",  32'(dbg_rdata),  32'd0);

        // Partial clear, interrupted by reset at word 70
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 70; i++) begin
            #1;
            check("clr1_wen",   32'(ram_wen),   32'd1);
            check("clr1_waddr", 32'(ram_waddr), 32'(i));
            check("clr1_gnt",   32'(dbg_gnt),   32'd0);
            if (i < 70) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_wen",  32'(ram_wen),  32'd0);
        check("midrst_addr", 32'(ram_waddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full clear: words 0..143 on consecutive cycles, core held, debug ignored
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("clr_wen",   32'(ram_wen),   32'd1);
            check("clr_waddr", 32'(ram_waddr), 32'(i));
            check("clr_wdata", 32'(ram_wdata), 32'd0);
            check("clr_ren",   32'(ram_ren),   32'd0);
            check("clr_gnt",   32'(dbg_gnt),   32'd0);
            check("clr_hold",  32'(cpu_hold),  32'd1);
            @(negedge clk);
        end

        // First RUN cycle: pending debug write of 0xA5 to 0x05 granted at once
        #1;
        check("run_hold",   32'(cpu_hold),  32'd0);
        check("dw_gnt",     32'(dbg_gnt),   32'd1);
        check("dw_wen",     32'(ram_wen),   32'd1);
        check("dw_waddr",   32'(ram_waddr), 32'h05);
        check("dw_wdata",   32'(ram_wdata), 32'hA5);
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        check("idle_gnt", 32'(dbg_gnt), 32'd0);
        check("idle_wen", 32'(ram_wen), 32'd0);
        @(negedge clk);

        dbg_read(8'h05, 8'hA5);
        #1;
        check("rvalid_pulse", 32'(dbg_rvalid), 32'd0);
        check("rdata_held",   32'(dbg_rdata),  32'hA5);
        dbg_read(8'h00, 8'h00);
        dbg_read(8'h8F, 8'h00);

        // Core writes 3 cycles while a debug write waits
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'h20;
        dbg_wdata = 8'h77;
        cpu_wen   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_waddr = L2D'(8'h10 + i);
            cpu_wdata = WIDTH'(8'h3C + 8'h11 * i);
            #1;
            check("cw_gnt",   32'(dbg_gnt),   32'd0);
            check("cw_wen",   32'(ram_wen),   32'd1);
            check("cw_waddr", 32'(ram_waddr), 32'(8'h10 + i));
            check("cw_wdata", 32'(ram_wdata), 32'(8'h3C + 8'h11 * i));
            @(negedge clk);
        end
        cpu_wen = 1'b0;
        #1;
        check("cw4_gnt",   32'(dbg_gnt),   32'd1);
        check("cw4_waddr", 32'(ram_waddr), 32'h20);
        check("cw4_wdata", 32'(ram_wdata), 32'h77);
        @(negedge clk);
        dbg_req = 1'b0;
        dbg_read(8'h10, 8'h3C);
        dbg_read(8'h12, 8'h5E);
        dbg_read(8'h20, 8'h77);

        // Core write and debug read to the same address in one cycle
        cpu_wen   = 1'b1;
        cpu_waddr = 8'h10;
        cpu_wdata = 8'h99;
        dbg_req   = 1'b1;
        dbg_we    = 1'b0;
        dbg_addr  = 8'h10;
        #1;
        check("col_gnt",   32'(dbg_gnt),   32'd1);
        check("col_wen",   32'(ram_wen),   32'd1);
        check("col_ren",   32'(ram_ren),   32'd1);
        check("col_raddr", 32'(ram_raddr), 32'h10);
        @(negedge clk);
        cpu_wen = 1'b0;
        dbg_req = 1'b0;
        #1;
        check("col_rvalid", 32'(dbg_rvalid), 32'd1);
        check("col_rdata",  32'(dbg_rdata),  32'h3C);
        @(negedge clk);
        dbg_read(8'h10, 8'h99);

        // Debug read, then core read: debug data held, core data passed through
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 8'h11;
        #1;
        check("dc_gnt", 32'(dbg_gnt), 32'd1);
        @(negedge clk);
        dbg_addr  = 8'h20;
        cpu_ren   = 1'b1;
        cpu_raddr = 8'h12;
        #1;
        check("dc_blk_gnt", 32'(dbg_gnt),    32'd0);
        check("dc_raddr",   32'(ram_raddr),  32'h12);
        check("dc_rvalid",  32'(dbg_rvalid), 32'd1);
        check("dc_rdata",   32'(dbg_rdata),  32'h4D);
        @(negedge clk);
        cpu_ren = 1'b0;
        #1;
        check("dc_cpu_rdata", 32'(cpu_rdata),  32'h5E);
        check("dc_hold_data", 32'(dbg_rdata),  32'h4D);
        check("dc_rvalid0",   32'(dbg_rvalid), 32'd0);
        check("dc_gnt2",      32'(dbg_gnt),    32'd1);
        check("dc_raddr2",    32'(ram_raddr),  32'h20);
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        check("dc_rdata2", 32'(dbg_rdata), 32'h77);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
